// File: rtl/pixel_pkg.sv
// Shared definitions for the pixel ALU path: opcodes, register ids, instruction layout,
// the no-side-effect BUBBLE word and the sequencer state encoding.
package pixel_pkg;

  localparam int INSTR_W       = 49;
  localparam int DEST_LSB      = 45;
  localparam int SRCA_LSB      = 41;
  localparam int SRCB_LSB      = 37;
  localparam int OP_LSB        = 33;
  localparam int USE_CONST_BIT = 32;
  localparam int CONST_LSB     = 0;

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_XOR = 4'd2;
  localparam logic [3:0] OP_ADD = 4'd3;
  localparam logic [3:0] OP_SUB = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_SHR = 4'd6;
  localparam logic [3:0] OP_MOV = 4'd7;

  localparam logic [3:0] REG_RESULT = 4'd11;
  localparam logic [3:0] REG_X      = 4'd12;
  localparam logic [3:0] REG_Y      = 4'd13;
  localparam logic [3:0] REG_F      = 4'd14;

  // dest 15 is neither a register nor the result, so the ALU discards the write
  localparam logic [INSTR_W-1:0] BUBBLE = {4'd15, 4'd0, 4'd0, OP_MOV, 1'b1, 32'd0};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_ISSUE,
    ST_DRAIN,
    ST_FRAME_WAIT
  } seq_state_t;

  function automatic logic [INSTR_W-1:0] make_instr(
    input logic [3:0]  dest,
    input logic [3:0]  srca,
    input logic [3:0]  srcb,
    input logic [3:0]  op,
    input logic        use_const,
    input logic [31:0] k
  );
    return {dest, srca, srcb, op, use_const, k};
  endfunction

endpackage

// File: rtl/pixel_sequencer_if.sv
// Pixel output stream: one held pixel with valid/ready; the slot clears on valid & ready.
interface pixel_sequencer_if;
  logic        pixel_valid;
  logic        pixel_ready;
  logic [15:0] pixel_x;
  logic [15:0] pixel_y;
  logic [11:0] pixel_value;

  modport master (output pixel_valid, pixel_x, pixel_y, pixel_value, input pixel_ready);
  modport slave  (input pixel_valid, pixel_x, pixel_y, pixel_value, output pixel_ready);
endinterface

// File: rtl/pixel_sequencer_program_ram.sv
// Shader program store: one write port, one registered read port (1-cycle latency), no reset
// so the loaded program survives a sequencer reset.
module program_ram #(
  parameter int AW = 4,
  parameter int DW = 49
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/pixel_sequencer.sv
// Raster-scan shader sequencer: prog_len instructions per pixel, prog_len+2 cycles per pixel, waits in
// START while the one-entry pixel slot is held by pixel_ready=0. SEQ_FRAME_WAIT_EN gates each new frame on frame_go.
module pixel_sequencer
  import pixel_pkg::*;
#(
  parameter int H_RES   = 320,
  parameter int V_RES   = 240,
  parameter int PROG_AW = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               prog_we,
  input  logic [PROG_AW-1:0] prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic [PROG_AW:0]   prog_len,
  input  logic               run,
  input  logic               frame_go,
  output logic [INSTR_W-1:0] instruction,
  output logic [31:0]        x_coord,
  output logic [31:0]        y_coord,
  output logic [31:0]        f_number,
  input  logic [11:0]        alu_value,
  pixel_sequencer_if.master  pix,
  output logic               busy
);
  localparam int LW = PROG_AW + 1;

  seq_state_t          state_q, state_d;
  logic [LW-1:0]       idx_q, idx_d;
  logic [31:0]         x_q, x_d, y_q, y_d, f_q, f_d;
  logic                vld_q, vld_d;
  logic [15:0]         px_q, px_d, py_q, py_d;
  logic [11:0]         pv_q, pv_d;

  logic [LW-1:0]       len_eff;
  logic [PROG_AW-1:0]  rd_addr;
  logic [INSTR_W-1:0]  ram_rdata;
  logic                ram_we, last_x, last_y, end_of_frame, slot_free;

  assign len_eff      = (prog_len == '0) ? LW'(1) : prog_len;
  assign last_x       = (x_q == 32'(H_RES - 1));
  assign last_y       = (y_q == 32'(V_RES - 1));
  assign end_of_frame = last_x && last_y;
  assign slot_free    = !vld_q || pix.pixel_ready;
  assign ram_we       = prog_we && (state_q == ST_IDLE);

  program_ram #(.AW(PROG_AW), .DW(INSTR_W)) u_program_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (rd_addr),
    .rdata (ram_rdata)
  );

`ifndef SEQ_FRAME_WAIT_EN
  logic unused_frame_go;
  assign unused_frame_go = frame_go;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    x_d     = x_q;
    y_d     = y_q;
    f_d     = f_q;
    vld_d   = vld_q && !pix.pixel_ready;
    px_d    = px_q;
    py_d    = py_q;
    pv_d    = pv_q;
    rd_addr = '0;

    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_START;
      end
      ST_START: begin
        // address 0 is presented here so instruction 0 is ready on the first ISSUE cycle
        if (slot_free) begin
          state_d = ST_ISSUE;
          idx_d   = '0;
        end
      end
      ST_ISSUE: begin
        rd_addr = PROG_AW'(idx_q + LW'(1));
        if (idx_q == len_eff - LW'(1)) state_d = ST_DRAIN;
        else                           idx_d   = idx_q + LW'(1);
      end
      ST_DRAIN: begin
        vld_d = 1'b1;
        px_d  = x_q[15:0];
        py_d  = y_q[15:0];
        pv_d  = alu_value;
        if (last_x) begin
          x_d = '0;
          y_d = last_y ? 32'd0 : y_q + 32'd1;
        end else begin
          x_d = x_q + 32'd1;
        end
`ifdef SEQ_FRAME_WAIT_EN
        if (!run)              state_d = ST_IDLE;
        else if (end_of_frame) state_d = ST_FRAME_WAIT;
        else                   state_d = ST_START;
`else
        if (end_of_frame) f_d = f_q + 32'd1;
        state_d = run ? ST_START : ST_IDLE;
`endif
      end
      ST_FRAME_WAIT: begin
`ifdef SEQ_FRAME_WAIT_EN
        if (!run) begin
          state_d = ST_IDLE;
          f_d     = f_q + 32'd1;
        end else if (frame_go) begin
          state_d = ST_START;
          f_d     = f_q + 32'd1;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      f_q     <= '0;
      vld_q   <= 1'b0;
      px_q    <= '0;
      py_q    <= '0;
      pv_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      y_q     <= y_d;
      f_q     <= f_d;
      vld_q   <= vld_d;
      px_q    <= px_d;
      py_q    <= py_d;
      pv_q    <= pv_d;
    end
  end

  assign instruction     = (state_q == ST_ISSUE) ? ram_rdata : BUBBLE;
  assign x_coord         = x_q;
  assign y_coord         = y_q;
  assign f_number        = f_q;
  assign busy            = (state_q != ST_IDLE);
  assign pix.pixel_valid = vld_q;
  assign pix.pixel_x     = px_q;
  assign pix.pixel_y     = py_q;
  assign pix.pixel_value = pv_q;
endmodule

// File: tb/tb_pixel_sequencer.sv
// Bench for pixel_sequencer on a 4x2 screen with a behavioural ALU; expected pixels are queued per scenario.
module tb_pixel_sequencer;
  import pixel_pkg::*;

  localparam int H = 4;
  localparam int V = 2;
  localparam int AW = 4;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [11:0] v;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [48:0]   prog_data = '0;
  logic [AW:0]   prog_len = '0;
  logic          run = 1'b0;
  logic          frame_go = 1'b0;
  logic [48:0]   instruction;
  logic [31:0]   x_coord, y_coord, f_number;
  logic [11:0]   alu_value = '0;
  logic          busy;

  pixel_sequencer_if pix_if ();

  pixel_sequencer #(.H_RES(H), .V_RES(V), .PROG_AW(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .prog_len    (prog_len),
    .run         (run),
    .frame_go    (frame_go),
    .instruction (instruction),
    .x_coord     (x_coord),
    .y_coord     (y_coord),
    .f_number    (f_number),
    .alu_value   (alu_value),
    .pix         (pix_if),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  exp_t        sb[$];
  logic [48:0] issued[$];
  logic [48:0] p1, pf, p_new, p_bad;
  logic [48:0] p3 [3];

  always @(posedge clk) cyc <= cyc + 1;

  // every real instruction the ALU sees, in order
  always @(posedge clk) begin
    if (!reset && instruction !== BUBBLE) issued.push_back(instruction);
  end

  // behavioural ALU: registered result, colour = top nibble of each byte of RGB888
  logic [31:0] alu_regs [0:15];
  logic [31:0] alu_a, alu_b, alu_res;
  logic [3:0]  alu_dest;

  function automatic logic [31:0] rd_src(input logic [3:0] s);
    case (s)
      REG_X:   return x_coord;
      REG_Y:   return y_coord;
      REG_F:   return f_number;
      default: return alu_regs[s];
    endcase
  endfunction

  always @(posedge clk) begin
    alu_dest = instruction[DEST_LSB +: 4];
    alu_a    = rd_src(instruction[SRCA_LSB +: 4]);
    alu_b    = instruction[USE_CONST_BIT] ? instruction[31:0] : rd_src(instruction[SRCB_LSB +: 4]);
    case (instruction[OP_LSB +: 4])
      OP_MOV:  alu_res = instruction[USE_CONST_BIT] ? instruction[31:0] : alu_a;
      OP_ADD:  alu_res = alu_a + alu_b;
      OP_OR:   alu_res = alu_a | alu_b;
      OP_SHL:  alu_res = alu_a << alu_b[4:0];
      default: alu_res = 32'd0;
    endcase
    if (alu_dest < 4'd12) alu_regs[alu_dest] <= alu_res;
    if (alu_dest == REG_RESULT) alu_value <= {alu_res[23:20], alu_res[15:12], alu_res[7:4]};
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    run   = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    issued.delete();
    sb.delete();
  endtask

  task automatic load_prog(input logic [AW-1:0] a, input logic [48:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    @(negedge clk);
    prog_we   = 1'b0;
  endtask

  // returns the next accepted pixel; called and returns at a negedge
  task automatic wait_pixel(output bit got, output exp_t o, output int at);
    got = 1'b0; o.x = '0; o.y = '0; o.v = '0; at = 0;
    for (int k = 0; k < 200; k++) begin
      if (pix_if.pixel_valid && pix_if.pixel_ready) begin
        got = 1'b1; o.x = pix_if.pixel_x; o.y = pix_if.pixel_y; o.v = pix_if.pixel_value; at = cyc;
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (instruction !== BUBBLE) begin n_fail++; $display("FAIL reset_instr got %h want %h", instruction, BUBBLE); end
    n_tests++; if ({x_coord, y_coord, f_number} !== 96'd0) begin n_fail++; $display("FAIL reset_xyf got %0d %0d %0d want 0 0 0", x_coord, y_coord, f_number); end
    n_tests++; if (pix_if.pixel_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", pix_if.pixel_valid); end
    n_tests++; if ({pix_if.pixel_x, pix_if.pixel_y, pix_if.pixel_value} !== 44'd0) begin n_fail++; $display("FAIL reset_slot got %0d %0d %h want 0 0 0", pix_if.pixel_x, pix_if.pixel_y, pix_if.pixel_value); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
  endtask

  task automatic test_single_instr();
    exp_t e, o; bit got; int at, prev;
    do_reset();
    load_prog(0, p1);
    prog_len = 1; pix_if.pixel_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      e.x = 16'(i % H); e.y = 16'((i / H) % V); e.v = 12'hACE; sb.push_back(e);
    end
    run = 1'b1;
    prev = 0;
    for (int i = 0; i < 10; i++) begin
      wait_pixel(got, o, at);
      n_tests++;
      if (!got) begin n_fail++; $display("FAIL single_timeout pixel %0d never arrived", i); break; end
      e = sb.pop_front();
      if ({o.x, o.y, o.v} !== {e.x, e.y, e.v}) begin
        n_fail++; $display("FAIL single_pixel%0d got (%0d,%0d)=%h want (%0d,%0d)=%h", i, o.x, o.y, o.v, e.x, e.y, e.v);
      end
      if (i > 0) begin
        n_tests++; if (at - prev != 3) begin n_fail++; $display("FAIL single_cadence%0d got %0d cycles want 3", i, at - prev); end
      end
      prev = at;
    end
    n_tests++; if (issued.size() != 10) begin n_fail++; $display("FAIL single_issue_count got %0d want 10", issued.size()); end
  endtask

  task automatic test_frame_wrap();
    exp_t e, o; bit got; int at;
    do_reset();
    load_prog(0, pf);
    prog_len = 1; pix_if.pixel_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      e.x = 16'(i % H); e.y = 16'((i / H) % V); e.v = (i < H * V) ? 12'hACE : 12'hACF; sb.push_back(e);
    end
    run = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wait_pixel(got, o, at);
      n_tests++;
      if (!got) begin n_fail++; $display("FAIL wrap_timeout pixel %0d never arrived", i); break; end
      e = sb.pop_front();
      if ({o.x, o.y, o.v} !== {e.x, e.y, e.v}) begin
        n_fail++; $display("FAIL wrap_pixel%0d got (%0d,%0d)=%h want (%0d,%0d)=%h", i, o.x, o.y, o.v, e.x, e.y, e.v);
      end
      if (i == H * V) begin
        n_tests++; if (f_number !== 32'd1) begin n_fail++; $display("FAIL wrap_fnumber got %0d want 1", f_number); end
      end
    end
  endtask

  task automatic test_stall();
    exp_t e, o; bit got; int at, prev, bad, k;
    do_reset();
    for (int i = 0; i < 3; i++) load_prog(AW'(i), p3[i]);
    prog_len = 3; pix_if.pixel_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      e.x = 16'(i % H); e.y = 16'((i / H) % V); e.v = 12'((i / H) * 16 + (i % H)); sb.push_back(e);
    end
    run = 1'b1;
    k = 0;
    while (!pix_if.pixel_valid && k < 100) begin @(negedge clk); k++; end
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      if (!pix_if.pixel_valid || pix_if.pixel_x !== 16'd0 || pix_if.pixel_y !== 16'd0 ||
          pix_if.pixel_value !== 12'h000 || instruction !== BUBBLE) bad++;
      @(negedge clk);
    end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL stall_hold got %0d bad cycles want 0", bad); end
    n_tests++; if (issued.size() != 3) begin n_fail++; $display("FAIL stall_issue_count got %0d want 3", issued.size()); end
    pix_if.pixel_ready = 1'b1;
    prev = 0;
    for (int i = 0; i < 5; i++) begin
      wait_pixel(got, o, at);
      n_tests++;
      if (!got) begin n_fail++; $display("FAIL stall_timeout pixel %0d never arrived", i); break; end
      e = sb.pop_front();
      if ({o.x, o.y, o.v} !== {e.x, e.y, e.v}) begin
        n_fail++; $display("FAIL stall_pixel%0d got (%0d,%0d)=%h want (%0d,%0d)=%h", i, o.x, o.y, o.v, e.x, e.y, e.v);
      end
      if (i > 0) begin
        n_tests++; if (at - prev != 5) begin n_fail++; $display("FAIL stall_cadence%0d got %0d cycles want 5", i, at - prev); end
      end
      prev = at;
    end
    bad = (issued.size() != 15) ? 1 : 0;
    for (int j = 0; j < issued.size() && j < 15; j++) if (issued[j] !== p3[j % 3]) bad++;
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL stall_sequence got %0d entries %0d bad want 15 in order", issued.size(), bad); end
  endtask

  task automatic test_run_drop();
    exp_t e, o; bit got, seen; int at, bad;
    do_reset();
    for (int i = 0; i < 3; i++) load_prog(AW'(i), p3[i]);
    prog_len = 3; pix_if.pixel_ready = 1'b1;
    e.x = 0; e.y = 0; e.v = 12'h000; sb.push_back(e);
    run = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      if (instruction === p3[1]) seen = 1'b1; else @(negedge clk);
    end
    n_tests++; if (!seen) begin n_fail++; $display("FAIL drop_find_instr1 got none want %h", p3[1]); end
    run = 1'b0;
    wait_pixel(got, o, at);
    e = sb.pop_front();
    n_tests++; if (!got || {o.x, o.y, o.v} !== {e.x, e.y, e.v}) begin
      n_fail++; $display("FAIL drop_pixel got %b (%0d,%0d)=%h want (0,0)=000", got, o.x, o.y, o.v);
    end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL drop_busy got %b want 0", busy); end
    n_tests++; if (issued.size() != 3) begin n_fail++; $display("FAIL drop_issue_count got %0d want 3", issued.size()); end
    bad = 0;
    repeat (10) begin if (pix_if.pixel_valid || busy) bad++; @(negedge clk); end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL drop_idle got %0d active cycles want 0", bad); end
    load_prog(2, p_new);
    for (int i = 1; i < 3; i++) begin e.x = 16'(i); e.y = 0; e.v = 12'h135; sb.push_back(e); end
    run = 1'b1;
    @(negedge clk);
    prog_we = 1'b1; prog_addr = 2; prog_data = p_bad;
    repeat (3) @(negedge clk);
    prog_we = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wait_pixel(got, o, at);
      n_tests++;
      if (!got) begin n_fail++; $display("FAIL reload_timeout pixel %0d never arrived", i); break; end
      e = sb.pop_front();
      if ({o.x, o.y, o.v} !== {e.x, e.y, e.v}) begin
        n_fail++; $display("FAIL reload_pixel%0d got (%0d,%0d)=%h want (%0d,%0d)=%h", i, o.x, o.y, o.v, e.x, e.y, e.v);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e, o; bit got, seen; int at;
    do_reset();
    load_prog(2, p3[2]);
    prog_len = 3; pix_if.pixel_ready = 1'b1;
    run = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      if (x_coord == 32'd2 && instruction === p3[1]) seen = 1'b1; else @(negedge clk);
    end
    n_tests++; if (!seen) begin n_fail++; $display("FAIL mid_find got none want instr1 at x=2"); end
    reset = 1'b1;
    @(negedge clk);
    n_tests++; if (instruction !== BUBBLE) begin n_fail++; $display("FAIL mid_instr got %h want %h", instruction, BUBBLE); end
    n_tests++; if ({x_coord, y_coord, f_number} !== 96'd0) begin n_fail++; $display("FAIL mid_xyf got %0d %0d %0d want 0 0 0", x_coord, y_coord, f_number); end
    n_tests++; if ({pix_if.pixel_valid, pix_if.pixel_x, pix_if.pixel_value, busy} !== 30'd0) begin
      n_fail++; $display("FAIL mid_slot got v=%b x=%0d val=%h busy=%b want 0 0 000 0", pix_if.pixel_valid, pix_if.pixel_x, pix_if.pixel_value, busy);
    end
    reset = 1'b0;
    issued.delete();
    for (int i = 0; i < 3; i++) begin e.x = 16'(i); e.y = 0; e.v = 12'(i); sb.push_back(e); end
    for (int i = 0; i < 3; i++) begin
      wait_pixel(got, o, at);
      n_tests++;
      if (!got) begin n_fail++; $display("FAIL rerun_timeout pixel %0d never arrived", i); break; end
      e = sb.pop_front();
      if ({o.x, o.y, o.v} !== {e.x, e.y, e.v}) begin
        n_fail++; $display("FAIL rerun_pixel%0d got (%0d,%0d)=%h want (%0d,%0d)=%h", i, o.x, o.y, o.v, e.x, e.y, e.v);
      end
    end
    n_tests++; if (issued.size() != 9) begin n_fail++; $display("FAIL rerun_issue_count got %0d want 9", issued.size()); end
  endtask

  task automatic test_len_zero();
    exp_t e, o; bit got; int at, prev, bad;
    do_reset();
    load_prog(0, p1);
    prog_len = 0; pix_if.pixel_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin e.x = 16'(i); e.y = 0; e.v = 12'hACE; sb.push_back(e); end
    run = 1'b1;
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      wait_pixel(got, o, at);
      n_tests++;
      if (!got) begin n_fail++; $display("FAIL len0_timeout pixel %0d never arrived", i); break; end
      e = sb.pop_front();
      if ({o.x, o.y, o.v} !== {e.x, e.y, e.v}) begin
        n_fail++; $display("FAIL len0_pixel%0d got (%0d,%0d)=%h want (%0d,%0d)=%h", i, o.x, o.y, o.v, e.x, e.y, e.v);
      end
      if (i > 0) begin
        n_tests++; if (at - prev != 3) begin n_fail++; $display("FAIL len0_cadence%0d got %0d cycles want 3", i, at - prev); end
      end
      prev = at;
    end
    bad = (issued.size() != 4) ? 1 : 0;
    for (int j = 0; j < issued.size(); j++) if (issued[j] !== p1) bad++;
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL len0_issue got %0d entries %0d bad want 4 copies of instr0", issued.size(), bad); end
  endtask

  initial begin
    pix_if.pixel_ready = 1'b0;
    p1    = make_instr(REG_RESULT, 4'd0, 4'd0, OP_MOV, 1'b1, 32'h00ABCDEF);
    pf    = make_instr(REG_RESULT, REG_F, 4'd0, OP_ADD, 1'b1, 32'h00ABCDEF);
    p3[0] = make_instr(4'd0, REG_X, 4'd0, OP_SHL, 1'b1, 32'd4);
    p3[1] = make_instr(4'd1, REG_Y, 4'd0, OP_SHL, 1'b1, 32'd12);
    p3[2] = make_instr(REG_RESULT, 4'd0, 4'd1, OP_OR, 1'b0, 32'd0);
    p_new = make_instr(REG_RESULT, 4'd0, 4'd0, OP_MOV, 1'b1, 32'h00123456);
    p_bad = make_instr(REG_RESULT, 4'd0, 4'd0, OP_MOV, 1'b1, 32'h00FEDCBA);
    test_reset();
    test_single_instr();
    test_frame_wrap();
    test_stall();
    test_run_drop();
    test_reset_mid();
    test_len_zero();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/pixel_sequencer.md
# pixel_sequencer

Drives the per-pixel ALU datapath. It holds the loaded shader program, scans the screen in raster order, and issues one 49-bit instruction per cycle with stable x/y/frame operands. It then captures each finished 12-bit pixel from the ALU and hands it downstream to the framebuffer writer over a valid/ready handshake. It sits between the host program loader and the ALU/framebuffer path.

## Interface
Parameters:
- H_RES, 320, pixels per line
- V_RES, 240, lines per frame
- PROG_AW, 4, program address width (depth 2^PROG_AW)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- prog_we  in  1  program write strobe
- prog_addr  in  PROG_AW  program write address
- prog_data  in  49  instruction word written
- prog_len  in  PROG_AW+1  instructions per pixel; 0 treated as 1
- run  in  1  level; high = scan frames
- frame_go  in  1  frame start pulse (used only with SEQ_FRAME_WAIT_EN)
- instruction  out  49  to ALU; BUBBLE when not issuing
- x_coord, y_coord, f_number  out  32 each  ALU operands
- alu_value  in  12  ALU registered output_value
- pixel_valid  out  1  pixel slot full
- pixel_ready  in  1  downstream accepts
- pixel_x, pixel_y  out  16 each  coordinates of held pixel
- pixel_value  out  12  held pixel colour
- busy  out  1  not in IDLE

## Operation
- BUBBLE = dest 4'd15, srca 0, srcb 0, op MOV, use_const 1, const 0. Its write targets a non-register, non-result address, so it has no ALU side effects.
- States:
  - IDLE: program writes accepted.
  - START: wait for slot free.
  - ISSUE: instructions 0..prog_len-1.
  - DRAIN: one capture cycle.
  - FRAME_WAIT.
- IDLE -> START when run=1.
- START -> ISSUE when no capture pending and (pixel_valid=0 or pixel_ready=1).
- ISSUE -> DRAIN after last instruction issued.
- DRAIN -> START; or FRAME_WAIT/START at end of frame; or IDLE if run=0.
- run=0 is sampled only at pixel boundaries. The current pixel always completes.
- prog_we is ignored outside IDLE.
- x_coord/y_coord are held constant for every instruction of a pixel. Raster order is x 0..H_RES-1, then y+1. After (H_RES-1, V_RES-1) both wrap to 0 and f_number increments. f_number wraps at 2^32.
- Capture: in DRAIN, alu_value, x, and y are loaded into the pixel slot and pixel_valid is set. The slot clears on pixel_valid & pixel_ready. Simultaneous clear and capture yields full.
- Reset:
  - State, counters, and slot return to initial values from any state, including mid-pixel.
  - Program RAM contents are retained.
  - Reset values: instruction=BUBBLE, x/y/f=0, pixel_valid=0, pixel_x/y/value=0, busy=0.

## Timing
- Program RAM is read synchronously. The first instruction appears on the cycle after START→ISSUE.
- Instruction k is valid for exactly one cycle. The ALU writes at the closing edge of that cycle.
- Last instruction at cycle c: DRAIN in c+1 (alu_value valid), pixel_valid high from c+2.
- Per-pixel cost with pixel_ready=1: prog_len+2 cycles. With prog_len=1 that is 3.
- Stalls never repeat an instruction. Any non-issuing cycle drives BUBBLE.

## Configuration
- SEQ_FRAME_WAIT_EN:
  - Defined: after the last pixel of a frame the FSM enters FRAME_WAIT, driving BUBBLE, and proceeds to START on frame_go=1. f_number increments on leaving FRAME_WAIT. run=0 in FRAME_WAIT -> IDLE.
  - Undefined: frame_go is ignored, FRAME_WAIT is unreachable, and frames run back-to-back.

## Structure
- Shared package pixel_pkg holds:
  - opcode constants OP_AND..OP_MOV
  - REG_X/REG_Y/REG_F/REG_RESULT
  - instruction field positions
  - BUBBLE constant
  - state enum
- One sub-module: program_ram, a single write port plus a synchronous read port, 49 bits × 2^PROG_AW, with no reset.

## Test plan
- Load a 1-instruction program (MOV result, const 0x00ABCDEF), run=1, ready=1 → pixels (0,0),(1,0),… each value 0xACE, one pixel every 3 cycles.
- Program of 3 instructions, ready held low 20 cycles after the first pixel → pixel_valid stays high with (0,0) held, instruction=BUBBLE throughout the stall, no instruction repeated, and (1,0) follows after ready rises.
- H_RES=4, V_RES=2 → after pixel (3,1), the next pixel is (0,0) with f_number=1. With SEQ_FRAME_WAIT_EN, no issue occurs until a frame_go pulse.
- run dropped during instruction 1 of 3 → remaining instructions issue, the pixel is captured, then IDLE with busy=0. prog_we in IDLE updates the program and prog_we while busy is ignored.
- reset asserted mid-ISSUE → next cycle instruction=BUBBLE, pixel_valid=0, x/y/f=0. Rerun produces the same program output without reloading.
- prog_len=0 → behaves exactly as prog_len=1.
